jac1_reg_trace: RTL and testbench
=================================

Name: jac1_reg_trace

Overview:
- Parametrised multi-channel register-value trace buffer for JAC1-class cores.
- Watches CHANNELS register buses, logs every value change as {timestamp, channel, value} into a DEPTH-entry circular buffer, and hands entries out over a valid/ready read port.
- Instantiated beside the core top. Lets benches and debug logic read register histories without waveform dumps.

Parameters:
- DATA_WIDTH, 8: width of each watched register value.
- CHANNELS, 2: number of watched register buses, >=1.
- DEPTH, 16: trace entries; power of two, >=2.
- TS_WIDTH, 16: timestamp counter width.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- sys_res  in  1  asynchronous, active-high reset.
- arm  in  1  level; 1 = capture enabled.
- mode_wrap  in  1  0 = stop when full, 1 = overwrite oldest.
- clear  in  1  synchronous buffer flush.
- ch_val  in  CHANNELS*DATA_WIDTH  packed register values; channel i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- rd_valid  out  1  head entry available.
- rd_ready  in  1  consumer accepts head.
- rd_data  out  DATA_WIDTH  head value.
- rd_chan  out  max(1,clog2(CHANNELS))  head channel index.
- rd_ts  out  TS_WIDTH  head timestamp.
- count  out  clog2(DEPTH)+1  stored entries.
- overflow  out  1  sticky; an entry was dropped or overwritten.
- state  out  2  00 IDLE, 01 CAPTURE, 10 FULL.

Behaviour:
Reset:
- sys_res asserted: state=IDLE, count=0, pointers=0, overflow=0, ts counter=0, baselines=0, rd_valid=0.
- rd_data, rd_chan and rd_ts are 0 while empty after reset.
- Async assert, sync-safe deassert. Reset mid-capture discards all entries.

Timestamp:
- Free-running counter, +1 every cycle, wraps modulo 2^TS_WIDTH.
- An entry stores the counter value at the write edge, before the increment.

State machine:
- IDLE -> CAPTURE on an edge with arm=1. That edge loads every channel baseline from ch_val and writes nothing.
- CAPTURE -> IDLE on arm=0.
- CAPTURE -> FULL when a write is needed, count==DEPTH, mode_wrap=0 and no pop happens that edge.
- FULL -> IDLE on arm=0. FULL never logs.
- The buffer is kept on return to IDLE and stays readable.

Change detection (CAPTURE only):
- Each edge, compare every channel with its baseline.
- If any differ, write one entry for the lowest-index differing channel and update only that channel's baseline.
- Other differing channels keep their old baseline and are logged on later edges with their then-current value. Result: at most one write per cycle, deterministic ordering.
- Entry becomes visible (count++, rd_valid=1 if previously empty) right after the write edge. Latency ch_val change -> rd_valid = 1 edge.

Read:
- First-word fall-through. rd_valid = (count!=0); rd_data, rd_chan and rd_ts show the head entry combinationally from storage.
- Pop on rd_valid && rd_ready. rd_ready while empty is ignored.

Full / simultaneous events:
- Write and pop on the same edge: count unchanged, no overflow, valid in every mode.
- Full, write, no pop, mode_wrap=1: oldest entry overwritten, read pointer advances, count stays DEPTH, overflow=1.
- Full, write, no pop, mode_wrap=0: entry dropped, overflow=1, state -> FULL.
- clear=1: count=0, pointers=0, overflow=0, and FULL -> CAPTURE if arm=1 (else IDLE).
  - clear overrides a same-edge write and pop.
  - Baselines keep tracking, so no spurious entries are logged.
- Pointers wrap modulo DEPTH.
- mode_wrap is sampled every edge; changing it while in FULL does not leave FULL; only clear or arm=0 does.

Test Plan:
- Reset: sys_res=1 for 2 cycles -> state=00, count=0, rd_valid=0, overflow=0. Hold arm=0, toggle ch_val -> count stays 0.
- Single change: DATA_WIDTH=8, CHANNELS=2; arm=1 with ch0=0x00; ch0=0x5A at ts=7 -> after 1 edge rd_valid=1, rd_data=0x5A, rd_chan=0, rd_ts=7. Pop -> count=0.
- Simultaneous change: ch0 0x00->0x11 and ch1 0x00->0x22 on the same edge at ts=T -> entries (ch0,0x11,T) then (ch1,0x22,T+1), in that order.
- Stop mode: DEPTH=16, mode_wrap=0, rd_ready=0; 17 distinct changes -> count=16, state=10, overflow=1. Entries hold values 1..16.
- Wrap mode: same stimulus with mode_wrap=1 -> count=16, state=01, overflow=1, head value=2, last value=17.
- Full with concurrent pop: count=16, change plus rd_ready=1 on one edge -> count=16, overflow=0. Then clear -> count=0, rd_valid=0. Then sys_res mid-capture -> all outputs return to reset values.

Source files
------------

// File: rtl/jac1_reg_trace.sv
// Multi-channel register-value trace buffer: logs {timestamp, channel, value}
// on every watched-register change and serves entries over a FWFT valid/ready port.
module jac1_reg_trace #(
    parameter int DATA_WIDTH = 8,
    parameter int CHANNELS   = 2,
    parameter int DEPTH      = 16,
    parameter int TS_WIDTH   = 16,
    localparam int AW        = $clog2(DEPTH),
    localparam int CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int CNTW      = AW + 1
) (
    input  logic                           clk,
    input  logic                           sys_res,
    input  logic                           arm,
    input  logic                           mode_wrap,
    input  logic                           clear,
    input  logic [CHANNELS*DATA_WIDTH-1:0] ch_val,
    output logic                           rd_valid,
    input  logic                           rd_ready,
    output logic [DATA_WIDTH-1:0]          rd_data,
    output logic [CW-1:0]                  rd_chan,
    output logic [TS_WIDTH-1:0]            rd_ts,
    output logic [CNTW-1:0]                count,
    output logic                           overflow,
    output logic [1:0]                     state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_CAPTURE = 2'b01,
        S_FULL    = 2'b10
    } state_t;

    state_t                  state_q, state_d;
    logic [TS_WIDTH-1:0]     ts_q;
    logic [DATA_WIDTH-1:0]   base_q [CHANNELS];
    logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0]         count_q;
    logic                    ovf_q;

    logic [DATA_WIDTH-1:0]   mem_data [DEPTH];
    logic [CW-1:0]           mem_chan [DEPTH];
    logic [TS_WIDTH-1:0]     mem_ts   [DEPTH];

    logic                    hit;
    logic [CW-1:0]           sel_ch;
    logic [DATA_WIDTH-1:0]   sel_val;
    logic                    need_wr, full, pop, do_store;

    // Lowest-index differing channel wins; scanning downward lets it overwrite higher ones.
    always_comb begin
        hit     = 1'b0;
        sel_ch  = '0;
        sel_val = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (ch_val[i*DATA_WIDTH +: DATA_WIDTH] != base_q[i]) begin
                hit     = 1'b1;
                sel_ch  = i[CW-1:0];
                sel_val = ch_val[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign need_wr  = (state_q == S_CAPTURE) && arm && hit;
    assign full     = (count_q == CNTW'(DEPTH));
    assign pop      = (count_q != '0) && rd_ready;
    // A full buffer only accepts the entry if a slot frees this edge or overwrite is allowed.
    assign do_store = need_wr && !clear && (!full || pop || mode_wrap);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (arm) state_d = S_CAPTURE;
            S_CAPTURE: begin
                if (!arm)
                    state_d = S_IDLE;
                else if (need_wr && full && !mode_wrap && !pop)
                    state_d = S_FULL;
            end
            S_FULL:    if (!arm) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        if (clear)
            state_d = arm ? S_CAPTURE : S_IDLE;
    end

    always_ff @(posedge clk or posedge sys_res) begin
        if (sys_res) begin
            state_q  <= S_IDLE;
            ts_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < CHANNELS; i++)
                base_q[i] <= '0;
        end else begin
            ts_q    <= ts_q + TS_WIDTH'(1);
            state_q <= state_d;

            // Baselines resync on arming and on a flush so stale values never produce entries.
            if ((state_q == S_IDLE && arm) || (clear && arm)) begin
                for (int i = 0; i < CHANNELS; i++)
                    base_q[i] <= ch_val[i*DATA_WIDTH +: DATA_WIDTH];
            end else if (need_wr) begin
                base_q[sel_ch] <= sel_val;
            end

            if (clear) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
                ovf_q    <= 1'b0;
            end else begin
                if (do_store)
                    wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop || (do_store && full))
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                if (need_wr && full && !pop)
                    ovf_q <= 1'b1;
                if (do_store && !pop && !full)
                    count_q <= count_q + CNTW'(1);
                else if (pop && !do_store)
                    count_q <= count_q - CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_store) begin
            mem_data[wr_ptr_q] <= sel_val;
            mem_chan[wr_ptr_q] <= sel_ch;
            mem_ts[wr_ptr_q]   <= ts_q;
        end
    end

    assign rd_valid = (count_q != '0);
    assign rd_data  = rd_valid ? mem_data[rd_ptr_q] : '0;
    assign rd_chan  = rd_valid ? mem_chan[rd_ptr_q] : '0;
    assign rd_ts    = rd_valid ? mem_ts[rd_ptr_q]   : '0;
    assign count    = count_q;
    assign overflow = ovf_q;
    assign state    = state_q;

endmodule

// File: tb/tb_jac1_reg_trace.sv
// Directed scoreboard bench for jac1_reg_trace with default parameters.
module tb_jac1_reg_trace;

    logic        clk = 1'b0;
    logic        sys_res, arm, mode_wrap, clear, rd_ready;
    logic [15:0] ch_val;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic [0:0]  rd_chan;
    logic [15:0] rd_ts;
    logic [4:0]  count;
    logic        overflow;
    logic [1:0]  state;

    jac1_reg_trace dut (
        .clk(clk), .sys_res(sys_res), .arm(arm), .mode_wrap(mode_wrap), .clear(clear),
        .ch_val(ch_val), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .rd_chan(rd_chan), .rd_ts(rd_ts), .count(count), .overflow(overflow), .state(state)
    );

    always #5 clk = ~clk;

    // Reference timestamp: free-running cycle count since reset release.
    logic [15:0] m_ts;
    always @(posedge clk or posedge sys_res)
        if (sys_res) m_ts <= '0;
        else         m_ts <= m_ts + 16'd1;

    typedef struct {
        logic [7:0]  d;
        logic        c;
        logic [15:0] t;
    } ent_t;
    ent_t sb[$];

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic c, input logic [7:0] d, input logic [15:0] t);
        ent_t e;
        e.c = c; e.d = d; e.t = t;
        sb.push_back(e);
    endtask

    task automatic check_head(input string tag);
        if (sb.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 32'(rd_valid), 32'd0);
        end else begin
            chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
            chk({tag, "_data"},  32'(rd_data),  32'(sb[0].d));
            chk({tag, "_chan"},  32'(rd_chan),  32'(sb[0].c));
            chk({tag, "_ts"},    32'(rd_ts),    32'(sb[0].t));
        end
    endtask

    task automatic pop_chk(input string tag);
        check_head(tag);
        if (sb.size() != 0) void'(sb.pop_front());
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
    endtask

    task automatic change_ch0(input logic [7:0] v, input logic log_it);
        ch_val[7:0] = v;
        if (log_it) push(1'b0, v, m_ts);
        step();
    endtask

    initial begin
        sys_res = 1'b1; arm = 1'b0; mode_wrap = 1'b0; clear = 1'b0; rd_ready = 1'b0;
        ch_val = '0;
        step(2);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_data", 32'(rd_data), 32'd0);
        chk("rst_ts", 32'(rd_ts), 32'd0);
        sys_res = 1'b0;

        // Unarmed: changes are ignored.
        ch_val = 16'h3355; step();
        ch_val = 16'h0000; step();
        chk("idle_count", 32'(count), 32'd0);
        chk("idle_state", 32'(state), 32'd0);

        // Arm: baseline load edge, no entry.
        arm = 1'b1; step();
        chk("arm_state", 32'(state), 32'd1);
        chk("arm_count", 32'(count), 32'd0);

        // Empty pop is ignored.
        rd_ready = 1'b1; step(); rd_ready = 1'b0;
        chk("empty_pop_count", 32'(count), 32'd0);

        // Single change.
        change_ch0(8'h5A, 1'b1);
        chk("single_count", 32'(count), 32'd1);
        pop_chk("single");
        chk("single_popped", 32'(count), 32'd0);

        // Simultaneous change on both channels: ch0 first, ch1 one edge later.
        ch_val = 16'h2211;
        push(1'b0, 8'h11, m_ts);
        push(1'b1, 8'h22, m_ts + 16'd1);
        step(2);
        chk("simul_count", 32'(count), 32'd2);
        pop_chk("simul0");
        pop_chk("simul1");

        // Stop mode: 17 changes, 17th dropped.
        mode_wrap = 1'b0;
        for (int v = 1; v <= 17; v++) change_ch0(8'(v), v <= 16);
        chk("stop_count", 32'(count), 32'd16);
        chk("stop_state", 32'(state), 32'd2);
        chk("stop_ovf", 32'(overflow), 32'd1);
        for (int k = 0; k < 16; k++) pop_chk("stop_rd");
        chk("stop_drained", 32'(count), 32'd0);
        chk("stop_stays_full", 32'(state), 32'd2);
        clear = 1'b1; step(); clear = 1'b0;
        chk("clr_state", 32'(state), 32'd1);
        chk("clr_ovf", 32'(overflow), 32'd0);

        // Wrap mode: 17 changes, oldest overwritten.
        mode_wrap = 1'b1;
        for (int v = 1; v <= 17; v++) change_ch0(8'(v), 1'b1);
        void'(sb.pop_front());
        chk("wrap_count", 32'(count), 32'd16);
        chk("wrap_state", 32'(state), 32'd1);
        chk("wrap_ovf", 32'(overflow), 32'd1);
        chk("wrap_head", 32'(rd_data), 32'd2);
        for (int k = 0; k < 16; k++) begin
            if (k == 15) chk("wrap_last", 32'(rd_data), 32'd17);
            pop_chk("wrap_rd");
        end
        chk("wrap_ovf_sticky", 32'(overflow), 32'd1);
        clear = 1'b1; step(); clear = 1'b0;

        // Full with a concurrent pop: no overflow, count unchanged.
        for (int v = 1; v <= 16; v++) change_ch0(8'(v), 1'b1);
        chk("fill_count", 32'(count), 32'd16);
        chk("fill_ovf", 32'(overflow), 32'd0);
        check_head("cpop_head");
        void'(sb.pop_front());
        rd_ready = 1'b1;
        change_ch0(8'h40, 1'b1);
        rd_ready = 1'b0;
        chk("cpop_count", 32'(count), 32'd16);
        chk("cpop_ovf", 32'(overflow), 32'd0);
        check_head("cpop_next");

        clear = 1'b1; step(); clear = 1'b0;
        sb.delete();
        chk("clear_count", 32'(count), 32'd0);
        chk("clear_valid", 32'(rd_valid), 32'd0);

        // Reset in the middle of capture.
        change_ch0(8'h41, 1'b0);
        chk("pre_rst_count", 32'(count), 32'd1);
        sys_res = 1'b1;
        #1;
        chk("mid_rst_state", 32'(state), 32'd0);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_valid", 32'(rd_valid), 32'd0);
        chk("mid_rst_ovf", 32'(overflow), 32'd0);
        chk("mid_rst_data", 32'(rd_data), 32'd0);
        chk("mid_rst_chan", 32'(rd_chan), 32'd0);
        step();
        sys_res = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
